// File: rtl/pll_lock_sequencer.sv
// Purpose: EHXPLLL power-up/recovery sequencer: pulses pll_rst, debounces LOCK, releases downstream reset, retries and faults.
// Latency: pll_lock fall to out_rst_n low in at most 3 clk (2-flop sync + registered FSM output).
// Backpressure: none; restart pulse overrides everything. Optional loss counter: define PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1000000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_rst,
   output logic       out_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [7:0] retries,
   output logic [7:0] loss_count,
   output logic [2:0] state_o
);

   localparam int M1 = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int M2 = (LOCK_TIMEOUT > M1) ? LOCK_TIMEOUT : M1;
   localparam int CW = $clog2(M2 + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO      = CW'(LOCK_TIMEOUT);
   localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [CW-1:0] tmr, tmr_nx;
   logic [7:0]    retries_nx;
   logic [7:0]    retries_inc;
   logic          lock_meta, lock_sync;

   assign state_o     = state;
   assign retries_inc = (retries == 8'hFF) ? retries : retries + 8'd1;

   // Bring the asynchronous PLL LOCK into the oscillator domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
      end
   end

   // Next-state, counter and retry decisions; restart wins over loss and timeout.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      tmr_nx     = tmr;
      retries_nx = retries;
      if (restart) begin
         state_nx   = S_RESET_PLL;
         cnt_nx     = '0;
         tmr_nx     = '0;
         retries_nx = 8'd0;
      end else begin
         case (state)
            S_RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  state_nx = S_WAIT_LOCK;
                  cnt_nx   = '0;
                  tmr_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            S_WAIT_LOCK, S_STABLE: begin
               if (tmr == TMO) begin
                  cnt_nx     = '0;
                  tmr_nx     = '0;
                  retries_nx = retries_inc;
                  state_nx   = (retries_inc >= RETRY_MAX) ? S_FAULT : S_RESET_PLL;
               end else begin
                  // tmr keeps counting across STABLE/WAIT_LOCK bounces so glitches cannot dodge the timeout
                  tmr_nx = tmr + 1'b1;
                  if (state == S_WAIT_LOCK) begin
                     if (lock_sync) begin
                        state_nx = S_STABLE;
                        cnt_nx   = '0;
                     end
                  end else if (!lock_sync) begin
                     state_nx = S_WAIT_LOCK;
                     cnt_nx   = '0;
                  end else if (cnt == STB_LAST) begin
                     state_nx = S_RELEASE;
                     cnt_nx   = '0;
                     tmr_nx   = '0;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (!lock_sync) begin
                  state_nx = S_RESET_PLL;
               end else begin
                  state_nx   = S_RUN;
                  retries_nx = 8'd0;
               end
            end
            S_RUN: begin
               if (!lock_sync) state_nx = S_RESET_PLL;
            end
            S_FAULT: state_nx = S_FAULT;
            default: begin
               state_nx = S_RESET_PLL;
               cnt_nx   = '0;
               tmr_nx   = '0;
            end
         endcase
      end
   end

   // State register plus outputs decoded from the next state so they are glitch-free flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RESET_PLL;
         cnt       <= '0;
         tmr       <= '0;
         retries   <= 8'd0;
         pll_rst   <= 1'b1;
         out_rst_n <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         tmr       <= tmr_nx;
         retries   <= retries_nx;
         pll_rst   <= (state_nx == S_RESET_PLL) || (state_nx == S_FAULT);
         out_rst_n <= (state_nx == S_RELEASE) || (state_nx == S_RUN);
         ready     <= (state_nx == S_RUN);
         fault     <= (state_nx == S_FAULT);
      end
   end

`ifdef PLL_SEQ_LOSS_CNT_EN
   logic       lock_lost;
   logic [7:0] loss_q;

   assign lock_lost  = ((state == S_RELEASE) || (state == S_RUN)) && !lock_sync && !restart;
   assign loss_count = loss_q;

   // Saturating count of lock losses after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= 8'd0;
      end else if (lock_lost && (loss_q != 8'hFF)) begin
         loss_q <= loss_q + 8'd1;
      end
   end
`else
   assign loss_count = 8'd0;
`endif

endmodule
